// File: rtl/shift8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift8_pkg
// Description : Shared constants for the shift8_ctrl LED-chaser sequencer:
//               data width, shift-mode codes, FSM state codes and the
//               ping-pong direction encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package shift8_pkg;

  localparam int DW = 8;

  // Shift modes carried by the start command
  localparam logic [1:0] MODE_ROL  = 2'd0;
  localparam logic [1:0] MODE_ROR  = 2'd1;
  localparam logic [1:0] MODE_PING = 2'd2;
  localparam logic [1:0] MODE_SHL  = 2'd3;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ping-pong travel direction
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : shift8_pkg
`default_nettype wire

// File: rtl/shift8_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : shift8_ctrl_if
// Description : Command/status bundle between board control logic and the
//               shift8_ctrl sequencer.
//                 start   : command strobe (sampled in IDLE only)
//                 mode    : shift mode (see shift8_pkg MODE_*)
//                 pattern : value loaded on an accepted start
//                 steps   : step count, 0 = run until stop
//                 stop    : abort request (sampled in RUN only)
//                 pause   : freeze request, present only when
//                           SHIFT8_CTRL_PAUSE_EN is defined
//                 data    : shift register contents
//                 busy    : high while running
//                 done    : one-cycle completion pulse
//               master = command source, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift8_ctrl_if;
  import shift8_pkg::*;

  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] pattern;
  logic [7:0]    steps;
  logic          stop;
`ifdef SHIFT8_CTRL_PAUSE_EN
  logic          pause;
`endif
  logic [DW-1:0] data;
  logic          busy;
  logic          done;

  modport master (
    output start, mode, pattern, steps, stop,
`ifdef SHIFT8_CTRL_PAUSE_EN
    output pause,
`endif
    input  data, busy, done
  );

  modport slave (
    input  start, mode, pattern, steps, stop,
`ifdef SHIFT8_CTRL_PAUSE_EN
    input  pause,
`endif
    output data, busy, done
  );

endinterface : shift8_ctrl_if
`default_nettype wire

// File: rtl/shift8_ctrl_dp.sv
`default_nettype none
// ============================================================================
// Module      : shift8_dp
// Description : 8-bit display shift register. Loads load_val on load,
//               otherwise applies one shift in the selected mode on step.
//               dir_flip tells the controller that the current ping-pong
//               step bounces off an end and reverses travel.
//   Ports : clk, rst       - clock, synchronous active-high reset
//           load, load_val - parallel load
//           step           - apply one shift this edge
//           mode, dir      - shift mode and ping-pong direction
//           data           - register contents
//           dir_flip       - ping-pong bounce indication
// Revision    : 1.0 - initial release
// ============================================================================
module shift8_dp
  import shift8_pkg::*;
#(
  parameter logic [DW-1:0] INI = 8'h01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          step,
  input  logic [1:0]    mode,
  input  logic          dir,
  output logic [DW-1:0] data,
  output logic          dir_flip
);

  logic [DW-1:0] r_data;
  logic [DW-1:0] w_next;
  logic          w_go_left;

  always_comb begin
    w_next    = r_data;
    dir_flip  = 1'b0;
    w_go_left = 1'b1;
    unique case (mode)
      MODE_ROL: w_next = {r_data[DW-2:0], r_data[DW-1]};
      MODE_ROR: w_next = {r_data[0], r_data[DW-1:1]};
      MODE_SHL: w_next = {r_data[DW-2:0], 1'b0};
      default: begin
        // Bounce when the lit end is reached, then shift the other way
        dir_flip  = (dir == DIR_LEFT) ? r_data[DW-1] : r_data[0];
        w_go_left = ((dir == DIR_LEFT) != dir_flip);
        w_next    = w_go_left ? {r_data[DW-2:0], 1'b0} : {1'b0, r_data[DW-1:1]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= INI;
    end else if (load) begin
      r_data <= load_val;
    end else if (step) begin
      r_data <= w_next;
    end
  end

  assign data = r_data;

endmodule : shift8_dp
`default_nettype wire

// File: rtl/shift8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift8_ctrl
// Description : Sequencer for an 8-bit LED-chaser shift register. Accepts a
//               start command (pattern, mode, steps), advances the register
//               one step per prescaler tick (every 2^NP clocks) and emits a
//               one-cycle done pulse on completion or stop.
//   Ports : clk  - system clock
//           rst  - synchronous active-high reset
//           bus  - shift8_ctrl_if.slave command/status bundle
//   Params: NP   - prescaler width in bits
//           INI  - data value after reset
//   Build : SHIFT8_CTRL_PAUSE_EN adds the pause input, which freezes the
//           prescaler, step counter and shifting while held in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift8_ctrl
  import shift8_pkg::*;
#(
  parameter int            NP  = 22,
  parameter logic [DW-1:0] INI = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  shift8_ctrl_if.slave bus
);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [NP-1:0] r_pre;
  logic [7:0]    r_cnt;
  logic [1:0]    r_mode;
  logic          r_dir;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] w_data;
  logic          w_dir_flip;
  logic          w_pause;
  logic          w_tick;
  logic          w_load;
  logic          w_advance;
  logic          w_step;

`ifdef SHIFT8_CTRL_PAUSE_EN
  assign w_pause = bus.pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_tick = &r_pre;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; stop takes priority over a coinciding tick
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.start) w_next_state = ST_RUN;
      ST_RUN: begin
        if (bus.stop) begin
          w_next_state = ST_DONE;
        end else if (!w_pause && w_tick && (r_cnt == 8'd1)) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Control outputs of the FSM
  always_comb begin
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_step    = 1'b0;
    unique case (r_state)
      ST_IDLE: w_load = bus.start;
      ST_RUN: begin
        w_advance = !bus.stop && !w_pause;
        w_step    = w_advance && w_tick;
      end
      default: ;
    endcase
  end

  // Prescaler, step counter, latched command and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_cnt  <= 8'd0;
      r_mode <= MODE_ROL;
      r_dir  <= DIR_LEFT;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == ST_RUN);
      r_done <= (w_next_state == ST_DONE);
      if (w_load) begin
        r_pre  <= '0;
        r_cnt  <= bus.steps;
        r_mode <= bus.mode;
        r_dir  <= DIR_LEFT;
      end else if (w_advance) begin
        r_pre <= r_pre + NP'(1);
        if (w_step) begin
          // A count of 0 means continuous, so it never decrements
          if (r_cnt > 8'd1) r_cnt <= r_cnt - 8'd1;
          if (w_dir_flip) r_dir <= ~r_dir;
        end
      end
    end
  end

  shift8_dp #(
    .INI (INI)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (bus.pattern),
    .step     (w_step),
    .mode     (r_mode),
    .dir      (r_dir),
    .data     (w_data),
    .dir_flip (w_dir_flip)
  );

  assign bus.data = w_data;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule : shift8_ctrl
`default_nettype wire

// File: tb/tb_shift8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift8_ctrl
// Description : Self-checking bench for shift8_ctrl. A per-command reference
//               model turns the step rules into the expected cycle-by-cycle
//               output stream and queues it; a monitor pops and compares
//               whenever busy or done is high, and checks data holds
//               otherwise. Pause is exercised when SHIFT8_CTRL_PAUSE_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift8_ctrl;

  localparam int         NP_TB = 1;
  localparam int         PER   = 1 << NP_TB;
  localparam logic [7:0] INI_V = 8'h01;

  typedef struct packed {
    logic [7:0] data;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  exp_t q[$];
  logic [7:0] hold_val;
  bit   mon_en;
  int   errors;
  int   checks;

  shift8_ctrl_if bus ();

  shift8_ctrl #(
    .NP  (NP_TB),
    .INI (INI_V)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step rules applied to a value; returns {dir_is_left, new_value}
  function automatic logic [8:0] model_step(input logic [1:0] m, input logic [7:0] d,
                                            input logic left);
    logic [7:0] n;
    logic       l;
    l = left;
    case (m)
      2'd0:    n = {d[6:0], d[7]};
      2'd1:    n = {d[0], d[7:1]};
      2'd3:    n = d << 1;
      default: begin
        if (l && d[7])       l = 1'b0;
        else if (!l && d[0]) l = 1'b1;
        n = l ? (d << 1) : (d >> 1);
      end
    endcase
    return {l, n};
  endfunction

  // Monitor: samples mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy === 1'b1 || bus.done === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got data=%h busy=%b done=%b, expected no activity",
                   bus.data, bus.busy, bus.done);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({bus.data, bus.busy, bus.done} !== e) begin
            errors++;
            $display("FAIL run_stream @%0t: got data=%h busy=%b done=%b, expected data=%h busy=%b done=%b",
                     $time, bus.data, bus.busy, bus.done, e.data, e.busy, e.done);
          end
          if (e.done) hold_val = e.data;
        end
      end else begin
        checks++;
        if (bus.data !== hold_val || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL idle_hold @%0t: got data=%h busy=%b done=%b, expected data=%h busy=0 done=0",
                   $time, bus.data, bus.busy, bus.done, hold_val);
        end
      end
    end
  end

  // Build the expected stream for one command, then drive it. Cycle k is the
  // k-th cycle after the start edge; stop/pause/rst driven in cycle k are
  // sampled at the edge closing it.
  task automatic run_cmd(input logic [1:0] m, input logic [7:0] pat, input logic [7:0] st,
                         input int stop_at, input int p_from, input int p_len, input int rst_at);
    logic [7:0] val;
    logic       dl;
    logic [8:0] r;
    int         ph, idx, c;
    bit         fin, rhit;
    val = pat; dl = 1'b1; ph = 0; idx = 0; c = 0; fin = 0; rhit = 0;
    while (!fin) begin
      c++;
      q.push_back('{data: val, busy: 1'b1, done: 1'b0});
      if (c == rst_at) begin
        rhit = 1; fin = 1;
      end else if (c == stop_at) begin
        fin = 1;
      end else if (!(p_len > 0 && c >= p_from && c < p_from + p_len)) begin
        ph++;
        if (ph == PER) begin
          ph  = 0;
          r   = model_step(m, val, dl);
          dl  = r[8];
          val = r[7:0];
          idx++;
          if (st != 0 && idx == int'(st)) fin = 1;
        end
      end
      if (c >= 2000) fin = 1;
    end
    if (!rhit) q.push_back('{data: val, busy: 1'b0, done: 1'b1});

    bus.start = 1'b1; bus.mode = m; bus.pattern = pat; bus.steps = st;
    @(posedge clk); #1;
    for (int k = 1; k <= c; k++) begin
      // Scramble command inputs during RUN: must be ignored
      bus.start   = k[0];
      bus.mode    = 2'($urandom);
      bus.pattern = 8'($urandom);
      bus.steps   = 8'($urandom);
      bus.stop    = (k == stop_at);
`ifdef SHIFT8_CTRL_PAUSE_EN
      bus.pause   = (p_len > 0 && k >= p_from && k < p_from + p_len);
`endif
      rst         = (k == rst_at);
      @(posedge clk); #1;
    end
    bus.stop = 1'b0;
    rst      = 1'b0;
`ifdef SHIFT8_CTRL_PAUSE_EN
    bus.pause = 1'b0;
`endif
    if (rhit) begin
      hold_val = INI_V;
    end else begin
      bus.start = 1'b1;          // start during DONE must be ignored
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; mon_en = 0; hold_val = INI_V;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 2'd0; bus.pattern = 8'h00; bus.steps = 8'd0; bus.stop = 1'b0;
`ifdef SHIFT8_CTRL_PAUSE_EN
    bus.pause = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1;
    repeat (10) @(posedge clk);
    #1;

    // Directed cases
    run_cmd(2'd0, 8'h81, 8'd3, 0, 0, 0, 0);
    run_cmd(2'd1, 8'h01, 8'd1, 0, 0, 0, 0);
    run_cmd(2'd2, 8'h40, 8'd4, 0, 0, 0, 0);
    run_cmd(2'd3, 8'hC0, 8'd2, 0, 0, 0, 0);
    run_cmd(2'd2, 8'h81, 8'd6, 0, 0, 0, 0);
    run_cmd(2'd0, 8'h01, 8'd0, 18, 0, 0, 0);   // continuous, wraps, stop on a tick
    run_cmd(2'd1, 8'h5A, 8'd5, 3, 0, 0, 0);    // stop before steps run out
    run_cmd(2'd0, 8'h11, 8'd0, 0, 0, 0, 7);    // reset mid-RUN
`ifdef SHIFT8_CTRL_PAUSE_EN
    run_cmd(2'd0, 8'h01, 8'd5, 0, 3, 6, 0);
    run_cmd(2'd2, 8'h20, 8'd0, 9, 4, 6, 0);    // stop honoured while paused
`endif

    // Randomized commands
    for (int i = 0; i < 25; i++) begin
      logic [1:0] m;
      logic [7:0] p;
      logic [7:0] s;
      int         sa;
      int         pf;
      int         pl;
      m  = 2'($urandom_range(0, 3));
      p  = 8'($urandom);
      s  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      sa = (s == 8'd0) ? int'($urandom_range(1, 24))
                       : (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : 0);
      pf = 0; pl = 0;
`ifdef SHIFT8_CTRL_PAUSE_EN
      pf = int'($urandom_range(1, 8));
      pl = int'($urandom_range(0, 5));
`endif
      run_cmd(m, p, s, sa, pf, pl, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
    end
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift8_ctrl
`default_nettype wire
